perceptron_predictor: RTL
=========================

Name: perceptron_predictor

Overview:
Perceptron branch direction predictor feeding the IF stage; it produces a taken/not-taken prediction for the fetch PC every cycle. Training requests come from EX at branch resolution and carry the PC, outcome, prediction, sum and history snapshot through the pipeline registers. Training is a 2-cycle read-modify-write backed by a 1-entry pending buffer. The global history register (GHR) updates non-speculatively at resolution.

Parameters:
PC_WIDTH, 8, fetch/resolve PC width
HISTORY, 4, GHR length = number of non-bias weights per row
WEIGHT_WIDTH, 6, signed weight width; saturates at [-32,+31]
TABLE_DEPTH, 32, perceptron rows (power of 2); index = pc[log2(TABLE_DEPTH)-1:0]
THETA, 21, training threshold (floor(1.93*HISTORY+14))
SUM_WIDTH, 10, signed dot-product width (WEIGHT_WIDTH+4)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
fetch_pc  in  PC_WIDTH  IF-stage PC
predict_taken  out  1  combinational; 1 when predict_sum >= 0
predict_sum  out  SUM_WIDTH  signed sum for fetch_pc with current GHR
predict_hist  out  HISTORY  current GHR, carried down the pipe
train_valid  in  1  EX branch resolved this cycle (single-cycle pulse)
train_pc  in  PC_WIDTH  PC of resolved branch
train_taken  in  1  actual outcome
train_pred  in  1  prediction made at fetch
train_sum  in  SUM_WIDTH  sum computed at fetch
train_hist  in  HISTORY  GHR snapshot used at fetch
busy  out  1  update FSM not IDLE
drop_pulse  out  1  1-cycle pulse: train request lost (pending full)
mispredict_cnt  out  16  feature-gated counter
train_cnt  out  16  feature-gated counter

Behaviour:
- Reset: all weights 0, GHR 0, FSM IDLE, pending empty, busy=0, drop_pulse=0, counters 0. Therefore predict_sum=0 and predict_taken=1 after reset.
- Prediction: x_i = +1 if hist bit i=1, else -1. Sum = bias + sum over i of (w_i*x_i), sign-extended to SUM_WIDTH. Purely combinational. No overflow is possible at the defaults.
- GHR: on every train_valid, regardless of busy, GHR <= {GHR[HISTORY-2:0], train_taken}. This keeps history in resolution order.
- Train condition: (train_pred != train_taken) || |train_sum| <= THETA. Requests that fail it are accepted but write nothing; they occupy ACCEPT only.
- FSM:
  - IDLE: on train_valid, latch the request and go to ACCEPT; busy=1 from the next cycle.
  - ACCEPT: read row; compute t = +1 if taken, else -1; w_i += t*x_i; bias += t; each result saturated. Go to WRITE if the train condition holds, else back to IDLE.
  - WRITE: write row at the clock edge. Go to IDLE, or to ACCEPT directly if pending is valid (pending is popped).
- Pending buffer: train_valid while busy fills the 1-entry pending buffer. If pending is already full, the new request is dropped: drop_pulse=1 for one cycle, but the GHR still shifts.
- Read-during-write: a fetch index equal to the row being written sees the old weights in that cycle and the new weights from the next cycle.
- Reset mid-update: the in-flight row write is abandoned and all state returns to reset values.
- Saturation: +31 + 1 = +31; -32 - 1 = -32.

Optional Feature:
PERCEPTRON_STATS_EN:
- Defined: train_cnt increments on every accepted (non-dropped) request. mispredict_cnt increments when train_pred != train_taken. Both wrap at 16 bits.
- Undefined: both outputs are tied to 0 and the counter registers are not built.

Decomposition:
- Shared package perceptron_pkg: SUM_WIDTH derivation, saturating-add function, FSM state enum {IDLE, ACCEPT, WRITE}, train-request struct (pc, taken, pred, sum, hist).
- One sub-module: perceptron_row_update. Combinational; takes a row, history and outcome and produces the saturated new row. It is reused by the bench as a reference model.

Test Plan:
- Reset, then fetch_pc=0x05 -> predict_sum=0, predict_taken=1, predict_hist=4'b0000, busy=0.
- Single train (pc=0x05, taken=0, pred=1, sum=0, hist=0000) -> 3 cycles later row 5 has bias=-1 and all w_i=+1. With GHR=0000 after reset, predict_sum=-5, predict_taken=0. GHR shifts to 0000 in the cycle after train_valid.
- 40 identical taken trainings of row 3 with hist=1111 and pred=0 -> bias and all w_i saturate at +31 and never wrap.
- train_valid on 3 consecutive cycles -> 1st in FSM, 2nd in pending, 3rd dropped with drop_pulse high 1 cycle. GHR holds all 3 outcomes. Final weights reflect exactly 2 updates.
- Correct prediction with train_sum=+30 (>THETA) -> no weight change, FSM ACCEPT->IDLE. With PERCEPTRON_STATS_EN: train_cnt=1, mispredict_cnt=0.
- Assert reset during WRITE of row 7 -> row 7 reads 0 after reset, busy=0, pending empty.

Source files
------------

// File: rtl/perceptron_pkg.sv
// Shared types, sizes and helpers for the perceptron branch predictor.
package perceptron_pkg;

    localparam int unsigned PC_WIDTH     = 8;
    localparam int unsigned HISTORY      = 4;
    localparam int unsigned WEIGHT_WIDTH = 6;
    localparam int unsigned TABLE_DEPTH  = 32;
    localparam int unsigned INDEX_WIDTH  = $clog2(TABLE_DEPTH);
    localparam int unsigned THETA        = 21;
    localparam int unsigned SUM_WIDTH    = WEIGHT_WIDTH + 4;
    localparam int unsigned CNT_WIDTH    = 16;
    localparam int unsigned ROW_WIDTH    = WEIGHT_WIDTH * (HISTORY + 1);

    typedef logic signed [WEIGHT_WIDTH-1:0] weight_t;
    typedef logic signed [SUM_WIDTH-1:0]    sum_t;

    localparam weight_t W_MAX   = weight_t'((2 ** (WEIGHT_WIDTH - 1)) - 1);
    localparam weight_t W_MIN   = weight_t'(-(2 ** (WEIGHT_WIDTH - 1)));
    localparam sum_t    THETA_S = sum_t'(THETA);

    // One perceptron row: bias plus one weight per history bit.
    typedef struct packed {
        logic [WEIGHT_WIDTH-1:0]              bias;
        logic [HISTORY-1:0][WEIGHT_WIDTH-1:0] w;
    } row_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        WRITE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic                taken;
        logic                pred;
        logic [SUM_WIDTH-1:0] sum;
        logic [HISTORY-1:0]  hist;
    } train_req_t;

    // Step a weight by +1/-1, sticking at the signed range limits.
    function automatic weight_t sat_add(input weight_t w, input logic inc);
        if (inc) begin
            return (w == W_MAX) ? w : weight_t'(w + weight_t'(1));
        end
        return (w == W_MIN) ? w : weight_t'(w - weight_t'(1));
    endfunction

    // Train on a mispredict or when the sum magnitude is within the threshold.
    function automatic logic needs_train(input train_req_t r);
        sum_t s;
        s = sum_t'(r.sum);
        return (r.pred != r.taken) || ((s <= THETA_S) && (s >= -THETA_S));
    endfunction

endpackage

// File: rtl/perceptron_row_update.sv
// Combinational training step: saturated row after one outcome under one history.
module perceptron_row_update
    import perceptron_pkg::*;
(
    input  logic [ROW_WIDTH-1:0] row,
    input  logic [HISTORY-1:0]   hist,
    input  logic                 taken,
    output logic [ROW_WIDTH-1:0] row_next_c
);

    row_t row_in;
    row_t row_out;

    assign row_in = row_t'(row);

    // Weight moves toward agreement: up when outcome matches the history bit.
    always_comb begin
        row_out      = row_in;
        row_out.bias = sat_add(weight_t'(row_in.bias), taken);
        for (int i = 0; i < HISTORY; i++) begin
            row_out.w[i] = sat_add(weight_t'(row_in.w[i]), taken == hist[i]);
        end
    end

    assign row_next_c = ROW_WIDTH'(row_out);

endmodule

// File: rtl/perceptron_predictor.sv
// Perceptron branch direction predictor with 2-cycle training and 1-entry pending buffer.
// Optional statistics counters are built when PERCEPTRON_STATS_EN is defined.
module perceptron_predictor
    import perceptron_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PC_WIDTH-1:0]  fetch_pc,
    output logic                 predict_taken,
    output logic [SUM_WIDTH-1:0] predict_sum,
    output logic [HISTORY-1:0]   predict_hist,
    input  logic                 train_valid,
    input  logic [PC_WIDTH-1:0]  train_pc,
    input  logic                 train_taken,
    input  logic                 train_pred,
    input  logic [SUM_WIDTH-1:0] train_sum,
    input  logic [HISTORY-1:0]   train_hist,
    output logic                 busy,
    output logic                 drop_pulse,
    output logic [CNT_WIDTH-1:0] mispredict_cnt,
    output logic [CNT_WIDTH-1:0] train_cnt
);

    row_t               table_q [TABLE_DEPTH];
    logic [HISTORY-1:0] ghr_q;
    state_t             state_q, state_d;
    train_req_t         req_q, req_d, pend_q, pend_d, in_req;
    logic               pend_valid_q, pend_valid_d;
    row_t               upd_row_q;
    row_t               acc_row;
    logic [ROW_WIDTH-1:0] upd_row_c;
    logic               busy_q, drop_q, drop_c, wr_en_c;
    row_t               fetch_row;
    sum_t               sum_c;
    logic               unused_bits;

    assign unused_bits = ^fetch_pc[PC_WIDTH-1:INDEX_WIDTH];

    // Dot product of the fetched row with the +/-1 history vector.
    always_comb begin
        fetch_row = table_q[fetch_pc[INDEX_WIDTH-1:0]];
        sum_c     = sum_t'(weight_t'(fetch_row.bias));
        for (int i = 0; i < HISTORY; i++) begin
            if (ghr_q[i]) begin
                sum_c = sum_t'(sum_c + sum_t'(weight_t'(fetch_row.w[i])));
            end else begin
                sum_c = sum_t'(sum_c - sum_t'(weight_t'(fetch_row.w[i])));
            end
        end
    end

    assign predict_sum   = SUM_WIDTH'(sum_c);
    assign predict_taken = ~sum_c[SUM_WIDTH-1];
    assign predict_hist  = ghr_q;

    assign in_req = '{pc: train_pc, taken: train_taken, pred: train_pred,
                      sum: train_sum, hist: train_hist};

    assign acc_row = table_q[req_q.pc[INDEX_WIDTH-1:0]];

    perceptron_row_update u_row_update (
        .row        (ROW_WIDTH'(acc_row)),
        .hist       (req_q.hist),
        .taken      (req_q.taken),
        .row_next_c (upd_row_c)
    );

    // Next-state, request hand-off and pending/drop decisions.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        drop_c       = 1'b0;
        wr_en_c      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pend_valid_q) begin
                    req_d        = pend_q;
                    state_d      = ACCEPT;
                    pend_valid_d = train_valid;
                    if (train_valid) begin
                        pend_d = in_req;
                    end
                end else if (train_valid) begin
                    req_d   = in_req;
                    state_d = ACCEPT;
                end
            end
            ACCEPT: begin
                state_d = needs_train(req_q) ? WRITE : IDLE;
            end
            WRITE: begin
                wr_en_c = 1'b1;
                if (pend_valid_q) begin
                    req_d        = pend_q;
                    pend_valid_d = 1'b0;
                    state_d      = ACCEPT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (train_valid && (state_q != IDLE)) begin
            if (pend_valid_q) begin
                drop_c = 1'b1;
            end else begin
                pend_d       = in_req;
                pend_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            req_q        <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            upd_row_q    <= '0;
            ghr_q        <= '0;
            busy_q       <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            busy_q       <= (state_d != IDLE);
            drop_q       <= drop_c;
            if (state_q == ACCEPT) begin
                upd_row_q <= row_t'(upd_row_c);
            end
            // History shifts in resolution order, even for dropped requests.
            if (train_valid) begin
                ghr_q <= {ghr_q[HISTORY-2:0], train_taken};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TABLE_DEPTH; i++) begin
                table_q[i] <= '0;
            end
        end else if (wr_en_c) begin
            table_q[req_q.pc[INDEX_WIDTH-1:0]] <= upd_row_q;
        end
    end

    assign busy       = busy_q;
    assign drop_pulse = drop_q;

`ifdef PERCEPTRON_STATS_EN
    logic [CNT_WIDTH-1:0] train_cnt_q, mispredict_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            train_cnt_q      <= '0;
            mispredict_cnt_q <= '0;
        end else if (train_valid && !drop_c) begin
            train_cnt_q <= CNT_WIDTH'(train_cnt_q + CNT_WIDTH'(1));
            if (train_pred != train_taken) begin
                mispredict_cnt_q <= CNT_WIDTH'(mispredict_cnt_q + CNT_WIDTH'(1));
            end
        end
    end

    assign train_cnt      = train_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;
`else
    assign train_cnt      = '0;
    assign mispredict_cnt = '0;
`endif

endmodule
